// File: rtl/even_parity_frame_rx_pkg.sv
// parity_pkg: shared FSM state type and frame constants for the even-parity receive path
package parity_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP, HOLD} rx_state_t;
  localparam int FRAME_DATA_BITS = 4;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/even_parity_frame_rx_if.sv
// even_parity_frame_rx_if: parallel frame bus with valid/ready handshake to the parity checker
interface even_parity_frame_rx_if;
  logic a_o, b_o, c_o, p_o, out_valid, out_ready, par_err;
  modport master(output a_o, b_o, c_o, p_o, out_valid, par_err, input out_ready);
  modport slave(input a_o, b_o, c_o, p_o, out_valid, par_err, output out_ready);
endinterface

// File: rtl/even_parity_frame_rx_sat_counter.sv
// sat_counter: incrementer that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/even_parity_frame_rx.sv
// even_parity_frame_rx: deserialises start/A/B/C/P/stop frames and holds them for the checker
module even_parity_frame_rx import parity_pkg::*; #(parameter int ERR_CNT_W = 8) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ser_in,
  input  logic                 ser_en,
  even_parity_frame_rx_if.master fo,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int IW = $clog2(FRAME_DATA_BITS);
  rx_state_t state;
  logic [IW-1:0] idx;
  logic [FRAME_DATA_BITS-1:0] sh;
  logic stop_ok, stop_bad, start_in_hold;
  assign stop_ok = state == STOP && ser_en && ser_in == STOP_LVL;
  assign stop_bad = state == STOP && ser_en && ser_in != STOP_LVL;
  assign start_in_hold = state == HOLD && ser_en && ser_in == START_LVL;
  // framed-out frames never reach the parity term, so no double counting
  sat_counter #(.W(ERR_CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .inc(stop_bad | (stop_ok & ^sh)), .cnt(err_cnt)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      sh <= '0;
      {fo.p_o, fo.c_o, fo.b_o, fo.a_o} <= '0;
      fo.out_valid <= 1'b0;
      fo.par_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun <= start_in_hold;
      case (state)
        IDLE: if (ser_en && ser_in == START_LVL) begin
          state <= DATA;
          idx <= '0;
        end
        DATA: if (ser_en) begin
          sh[idx] <= ser_in;
          idx <= idx + 1'b1;
          if (idx == IW'(FRAME_DATA_BITS - 1)) state <= STOP;
        end
        STOP: if (ser_en) begin
          if (stop_ok) begin
            {fo.p_o, fo.c_o, fo.b_o, fo.a_o} <= sh;
            fo.par_err <= ^sh;
            fo.out_valid <= 1'b1;
            state <= HOLD;
          end else state <= IDLE;
        end
        HOLD: if (fo.out_ready) begin
          fo.out_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_even_parity_frame_rx.sv
// tb_even_parity_frame_rx: directed and random frames checked against a per-frame reference model
module tb_even_parity_frame_rx;
  logic clk = 0, rst_n = 0, ser_in = 1, ser_en = 0, out_ready = 0;
  logic fe, ov, fe2, ov2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  int n_chk = 0, n_fail = 0, errs = 0;
  even_parity_frame_rx_if fo();
  even_parity_frame_rx_if fo2();
  assign fo.out_ready = out_ready;
  assign fo2.out_ready = out_ready;
  always #5 clk = ~clk;
  even_parity_frame_rx #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_en(ser_en), .fo(fo),
    .frame_err(fe), .overrun(ov), .err_cnt(cnt)
  );
  even_parity_frame_rx #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_en(ser_en), .fo(fo2),
    .frame_err(fe2), .overrun(ov2), .err_cnt(cnt2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic samp(input logic v, input int gap);
    repeat (gap) begin
      ser_en = 0;
      ser_in = 1'($urandom);
      tick();
    end
    ser_en = 1;
    ser_in = v;
    tick();
    ser_en = 0;
  endtask
  task automatic check_cnt;
    check("err_cnt", 32'(cnt), errs > 255 ? 255 : errs);
    check("err_cnt_w2", 32'(cnt2), errs > 3 ? 3 : errs);
  endtask
  task automatic check_zero;
    check("rst_bits", {28'd0, fo.p_o, fo.c_o, fo.b_o, fo.a_o}, 0);
    check("rst_valid", 32'(fo.out_valid), 0);
    check("rst_par_err", 32'(fo.par_err), 0);
    check("rst_flags", {30'd0, fe, ov}, 0);
    check_cnt();
  endtask
  // d = {P,C,B,A}; model: parity is the XOR of the four bits, errors tally per frame
  task automatic frame(input logic [3:0] d, input logic stop, input int gap, input int stall, input bit ovr);
    out_ready = (stall == 0);
    samp(1'b0, gap);
    for (int i = 0; i < 4; i++) samp(d[i], gap);
    samp(stop, gap);
    if (!stop) begin
      errs++;
      check("frame_err", 32'(fe), 1);
      check("valid_on_fe", 32'(fo.out_valid), 0);
      check_cnt();
      tick();
      check("frame_err_len", 32'(fe), 0);
      check("valid_after_fe", 32'(fo.out_valid), 0);
    end else begin
      errs += 32'(^d);
      check_cnt();
      for (int k = 0; k <= stall; k++) begin
        check("valid_hold", 32'(fo.out_valid), 1);
        check("abcp", {28'd0, fo.p_o, fo.c_o, fo.b_o, fo.a_o}, 32'(d));
        check("abcp_w2", {28'd0, fo2.p_o, fo2.c_o, fo2.b_o, fo2.a_o}, 32'(d));
        check("par_err", 32'(fo.par_err), 32'(^d));
        check("overrun", 32'(ov), 32'(ovr && k == 1));
        ser_en = ovr && k == 0;
        ser_in = 0;
        out_ready = (k == stall);
        tick();
        ser_en = 0;
      end
      check("valid_drop", 32'(fo.out_valid), 0);
      check("overrun_len", 32'(ov), 0);
    end
  endtask
  initial begin
    logic [3:0] d;
    bit ovr;
    repeat (3) tick();
    check_zero();
    rst_n = 1;
    tick();
    frame(4'b0101, 1, 0, 0, 0);
    frame(4'b0111, 1, 0, 5, 0);
    frame(4'b0000, 0, 0, 0, 0);
    frame(4'b0011, 1, 0, 3, 1);
    frame(4'b1001, 1, 0, 0, 0);
    frame(4'b0101, 1, 2, 0, 0);
    out_ready = 1;
    samp(1'b0, 0);
    samp(1'b1, 0);
    samp(1'b0, 0);
    rst_n = 0;
    tick();
    errs = 0;
    check_zero();
    rst_n = 1;
    repeat (3) begin
      tick();
      check("ghost_valid", 32'(fo.out_valid), 0);
    end
    frame(4'b0101, 1, 0, 0, 0);
    repeat (5) frame(4'b0001, 1, 0, 0, 0);
    check("sat_w2", 32'(cnt2), 3);
    repeat (60) begin
      d = 4'($urandom);
      ovr = $urandom_range(0, 3) == 0;
      frame(d, $urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(ovr ? 1 : 0, 4), ovr);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
